dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the 64-bit data memory. It shares one synchronous single-port data RAM between the CPU memory stage and the debug/loader port. Each access runs as a fixed three-state sequence, with round-robin fairness and out-of-range address detection (the ADR status source). The block sits between the memory stage and the data RAM, and replaces direct combinational RAM access.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/data_ram.sv | 33 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory arbiter, its bus interface and the data RAM.
package dmem_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned REQ_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  // Access fields captured at acceptance; only the RAM-visible address bits are kept
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } access_s;

  function automatic logic addr_out_of_range(input logic [REQ_ADDR_W-1:0] addr);
    return |addr[REQ_ADDR_W-1:ADDR_W];
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, RAM and status signals shared by the arbiter, the data RAM and the requesters.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [REQ_ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_err;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [REQ_ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0]     dbg_wdata;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [DATA_W-1:0]     dbg_rdata;
  logic                  dbg_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  busy
  );

  modport ram (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_ram.sv
// Synchronous single-port data RAM with one-cycle read; reset reloads the fixed test words.
module data_ram
  import dmem_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.ram  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read returns the pre-write contents on a write cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[ADDR_W'(7)]  <= DATA_W'(24);
      r_mem[ADDR_W'(24)] <= DATA_W'(17);
      r_mem[ADDR_W'(32)] <= DATA_W'(88);
      r_mem[ADDR_W'(47)] <= DATA_W'(55);
      r_rdata            <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        r_mem[bus.mem_addr] <= bus.mem_wdata;
      end
      r_rdata <= r_mem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the CPU memory stage and the debug port; every access runs
// IDLE -> ISSUE -> WAIT, out-of-range accesses complete with err and never strobe the RAM.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  req_id_e           r_last_gnt;
  req_id_e           r_owner;
  req_id_e           w_winner;
  access_s           r_acc;
  access_s           w_req_acc;
  logic              r_err_l;
  logic              w_req_err;
  logic              w_accept;
  logic              w_complete;
  logic              w_mem_en;

  logic              r_cpu_gnt;
  logic              r_dbg_gnt;
  logic              r_cpu_rvalid;
  logic              r_dbg_rvalid;
  logic              r_cpu_err;
  logic              r_dbg_err;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              r_busy;

  // On a tie the side not granted last wins
  always_comb begin
    w_winner = REQ_CPU;
    if (bus.cpu_req && bus.dbg_req) begin
      w_winner = (r_last_gnt == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (bus.dbg_req) begin
      w_winner = REQ_DBG;
    end
  end

  always_comb begin
    w_req_acc = '0;
    w_req_err = 1'b0;
    if (w_winner == REQ_CPU) begin
      w_req_acc.we    = bus.cpu_we;
      w_req_acc.addr  = bus.cpu_addr[ADDR_W-1:0];
      w_req_acc.wdata = bus.cpu_wdata;
      w_req_err       = addr_out_of_range(bus.cpu_addr);
    end else begin
      w_req_acc.we    = bus.dbg_we;
      w_req_acc.addr  = bus.dbg_addr[ADDR_W-1:0];
      w_req_acc.wdata = bus.dbg_wdata;
      w_req_err       = addr_out_of_range(bus.dbg_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          w_state_nxt = ISSUE;
          w_accept    = 1'b1;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        w_state_nxt = IDLE;
        w_complete  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Acceptance capture, completion reporting and per-side status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt   <= REQ_DBG;
      r_owner      <= REQ_CPU;
      r_acc        <= '0;
      r_err_l      <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_cpu_gnt    <= w_accept && (w_winner == REQ_CPU);
      r_dbg_gnt    <= w_accept && (w_winner == REQ_DBG);
      r_cpu_rvalid <= w_complete && (r_owner == REQ_CPU);
      r_dbg_rvalid <= w_complete && (r_owner == REQ_DBG);
      r_cpu_err    <= w_complete && (r_owner == REQ_CPU) && r_err_l;
      r_dbg_err    <= w_complete && (r_owner == REQ_DBG) && r_err_l;
      r_busy       <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_owner    <= w_winner;
        r_last_gnt <= w_winner;
        r_acc      <= w_req_acc;
        r_err_l    <= w_req_err;
      end
      if (w_complete && !r_acc.we) begin
        if (r_owner == REQ_CPU) begin
          r_cpu_rdata <= r_err_l ? '0 : bus.mem_rdata;
        end else begin
          r_dbg_rdata <= r_err_l ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  // Reset gates the strobe so an interrupted access never reaches the RAM
  always_comb begin
    w_mem_en = 1'b0;
    if (r_state == ISSUE) begin
      w_mem_en = !r_err_l && !reset;
    end
  end

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = r_acc.we && w_mem_en;
  assign bus.mem_addr  = r_acc.addr;
  assign bus.mem_wdata = r_acc.wdata;

  assign bus.cpu_gnt    = r_cpu_gnt;
  assign bus.dbg_gnt    = r_dbg_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.dbg_rvalid = r_dbg_rvalid;
  assign bus.cpu_err    = r_cpu_err;
  assign bus.dbg_err    = r_dbg_err;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with the data RAM attached; expected values are hand-derived.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   mem_en_cnt;
  int   clash_cnt;

  dmem_arbiter_if bus();

  dmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  data_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) mem_en_cnt++;
    if ((bus.cpu_gnt && bus.dbg_gnt) || (bus.cpu_rvalid && bus.dbg_rvalid)) clash_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic is_dbg, input logic we,
                           input logic [63:0] addr, input logic [63:0] wd);
    if (is_dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
  endtask

  task automatic stop_req();
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
  endtask

  task automatic test_reset();
    stop_req();
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_err, bus.dbg_err,
         bus.busy, bus.mem_en, bus.mem_we} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000000", {bus.cpu_gnt, bus.dbg_gnt,
               bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_err, bus.dbg_err, bus.busy, bus.mem_en, bus.mem_we});
    end
    checks++;
    if ({bus.cpu_rdata, bus.dbg_rdata} !== 128'b0) begin
      errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", bus.cpu_rdata, bus.dbg_rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single_read();
    start_req(1'b0, 1'b0, 64'd24, 64'd0);
    tick();
    checks++;
    if ({bus.cpu_gnt, bus.dbg_gnt, bus.busy} !== 3'b101) begin
      errors++; $display("FAIL rd_gnt: got %b expected 101", {bus.cpu_gnt, bus.dbg_gnt, bus.busy});
    end
    stop_req();
    tick();
    checks++;
    if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_pulse: got %b expected 0", bus.cpu_gnt); end
    tick();
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_err, bus.busy} !== 3'b100) begin
      errors++; $display("FAIL rd_done: got %b expected 100", {bus.cpu_rvalid, bus.cpu_err, bus.busy});
    end
    checks++;
    if (bus.cpu_rdata !== 64'd17) begin errors++; $display("FAIL rd_data: got %0d expected 17", bus.cpu_rdata); end
    checks++;
    if ({bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_err} !== 3'b000 || bus.dbg_rdata !== 64'd0) begin
      errors++; $display("FAIL rd_dbg_quiet: got %b %h expected 000 0",
                         {bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_err}, bus.dbg_rdata);
    end
    tick();
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 64'd17) begin
      errors++; $display("FAIL rd_hold: got %b %0d expected 0 17", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_write_read();
    start_req(1'b1, 1'b1, 64'd100, 64'hDEAD_BEEF);
    tick();
    checks++;
    if ({bus.dbg_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we} !== 4'b1011) begin
      errors++; $display("FAIL wr_issue: got %b expected 1011", {bus.dbg_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we});
    end
    checks++;
    if (bus.mem_addr !== 10'd100 || bus.mem_wdata !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_bus: got %0d %h expected 100 deadbeef", bus.mem_addr, bus.mem_wdata);
    end
    stop_req();
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we} !== 2'b00) begin
      errors++; $display("FAIL wr_wait_mem: got %b expected 00", {bus.mem_en, bus.mem_we});
    end
    tick();
    checks++;
    if ({bus.dbg_rvalid, bus.dbg_err, bus.cpu_rvalid} !== 3'b100 || bus.dbg_rdata !== 64'd0) begin
      errors++; $display("FAIL wr_done: got %b %h expected 100 0",
                         {bus.dbg_rvalid, bus.dbg_err, bus.cpu_rvalid}, bus.dbg_rdata);
    end
    start_req(1'b0, 1'b0, 64'd100, 64'd0);
    tick();
    stop_req();
    tick();
    tick();
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_readback: got %b %h expected 1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_tie();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_req(1'b0, 1'b0, 64'd7, 64'd0);
    start_req(1'b1, 1'b0, 64'd47, 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({bus.cpu_gnt, bus.dbg_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_gnt%0d: got %b expected %b", k, {bus.cpu_gnt, bus.dbg_gnt},
                           (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      tick();
      if (k % 2 == 0) begin
        checks++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b10 || bus.cpu_rdata !== 64'd24) begin
          errors++; $display("FAIL tie_done%0d: got %b %0d expected 10 24", k,
                             {bus.cpu_rvalid, bus.dbg_rvalid}, bus.cpu_rdata);
        end
      end else begin
        checks++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b01 || bus.dbg_rdata !== 64'd55) begin
          errors++; $display("FAIL tie_done%0d: got %b %0d expected 01 55", k,
                             {bus.cpu_rvalid, bus.dbg_rvalid}, bus.dbg_rdata);
        end
      end
    end
    stop_req();
    tick();
  endtask

  task automatic test_out_of_range();
    int en_before;
    start_req(1'b0, 1'b1, 64'd0, 64'hA5A5);
    tick();
    stop_req();
    tick();
    tick();
    en_before = mem_en_cnt;
    start_req(1'b0, 1'b1, 64'd1024, 64'h1234);
    tick();
    checks++;
    if ({bus.cpu_gnt, bus.mem_en, bus.mem_we} !== 3'b100) begin
      errors++; $display("FAIL oor_wr_issue: got %b expected 100", {bus.cpu_gnt, bus.mem_en, bus.mem_we});
    end
    stop_req();
    tick();
    tick();
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_err} !== 2'b11 || bus.cpu_rdata !== 64'd24) begin
      errors++; $display("FAIL oor_wr_done: got %b %0d expected 11 24", {bus.cpu_rvalid, bus.cpu_err}, bus.cpu_rdata);
    end
    start_req(1'b0, 1'b0, 64'd1024, 64'd0);
    tick();
    stop_req();
    tick();
    tick();
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_err} !== 2'b11 || bus.cpu_rdata !== 64'd0) begin
      errors++; $display("FAIL oor_rd_done: got %b %0d expected 11 0", {bus.cpu_rvalid, bus.cpu_err}, bus.cpu_rdata);
    end
    checks++;
    if (mem_en_cnt !== en_before) begin
      errors++; $display("FAIL oor_mem_en: got %0d strobes expected 0", mem_en_cnt - en_before);
    end
    start_req(1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    stop_req();
    tick();
    tick();
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_err} !== 2'b10 || bus.cpu_rdata !== 64'hA5A5) begin
      errors++; $display("FAIL oor_alias: got %b %h expected 10 a5a5", {bus.cpu_rvalid, bus.cpu_err}, bus.cpu_rdata);
    end
  endtask

  task automatic test_reset_mid_op();
    start_req(1'b0, 1'b1, 64'd32, 64'd5);
    tick();
    checks++;
    if ({bus.cpu_gnt, bus.mem_en, bus.mem_we} !== 3'b111) begin
      errors++; $display("FAIL rst_pre: got %b expected 111", {bus.cpu_gnt, bus.mem_en, bus.mem_we});
    end
    reset = 1'b1;
    stop_req();
    #1;
    checks++;
    if ({bus.mem_en, bus.mem_we} !== 2'b00) begin
      errors++; $display("FAIL rst_mem_gate: got %b expected 00", {bus.mem_en, bus.mem_we});
    end
    tick();
    checks++;
    if ({bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_err, bus.busy} !== 4'b0000 || bus.cpu_rdata !== 64'd0) begin
      errors++; $display("FAIL rst_outputs: got %b %h expected 0000 0",
                         {bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_err, bus.busy}, bus.cpu_rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_rvalid%0d: got 1 expected 0", i); end
    end
    start_req(1'b0, 1'b0, 64'd32, 64'd0);
    tick();
    stop_req();
    tick();
    tick();
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 64'd88) begin
      errors++; $display("FAIL rst_readback: got %b %0d expected 1 88", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    start_req(1'b0, 1'b0, 64'd7, 64'd0);
    tick();
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b expected 1", bus.cpu_gnt); end
    bus.cpu_addr = 64'd47;
    tick();
    tick();
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 64'd24 || bus.cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got %b %0d %b expected 1 24 0", bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_gnt);
    end
    tick();
    checks++;
    if ({bus.cpu_gnt, bus.cpu_rvalid, bus.busy} !== 3'b101 || bus.cpu_rdata !== 64'd24) begin
      errors++; $display("FAIL b2b_gnt1: got %b %0d expected 101 24", {bus.cpu_gnt, bus.cpu_rvalid, bus.busy}, bus.cpu_rdata);
    end
    stop_req();
    tick();
    tick();
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 64'd55) begin
      errors++; $display("FAIL b2b_second: got %b %0d expected 1 55", bus.cpu_rvalid, bus.cpu_rdata);
    end
    tick();
  endtask

  task automatic test_exclusive();
    checks++;
    if (clash_cnt !== 0) begin
      errors++; $display("FAIL exclusive: got %0d overlapping cycles expected 0", clash_cnt);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    mem_en_cnt = 0;
    clash_cnt  = 0;
    reset      = 1'b1;
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_out_of_range();
    test_reset_mid_op();
    test_back_to_back();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
